pipe_cla_adder: RTL

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_cla_adder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_cla_adder.sv
// Pipelined 4-bit-group carry-lookahead adder/subtractor with valid/ready flow.
// Define PIPE_CLA_ADDER_SAT_EN to saturate s to the signed extreme on overflow.
module pipe_cla_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / 4;

   function automatic logic [4:0] cla4(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       c0
   );
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a | b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], a ^ b ^ c[3:0]};
   endfunction

   logic             adv;
   logic             v_in  [STAGES];
   logic [WIDTH-1:0] a_in  [STAGES];
   logic [WIDTH-1:0] b_in  [STAGES];
   logic             c_in  [STAGES];
   logic [WIDTH-1:0] ps_in [STAGES];

   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             ov_q;
   logic             out_valid_q;

   // The whole pipeline freezes only while a result waits on the consumer.
   assign adv      = !(out_valid_q && !out_ready);
   assign in_ready = !rst_n || adv;

   assign v_in[0]  = in_valid;
   assign a_in[0]  = x;
   assign b_in[0]  = sub ? ~y : y;
   assign c_in[0]  = sub | ci;
   assign ps_in[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] sum_c;
      logic             cy_c;
      logic [4:0]       grp_c;

      always_comb begin
         sum_c = ps_in[k];
         cy_c  = c_in[k];
         grp_c = '0;
         for (int g = 0; g < NG; g++) begin
            grp_c = cla4(a_in[k][k*SW+4*g +: 4],
                         b_in[k][k*SW+4*g +: 4], cy_c);
            sum_c[k*SW+4*g +: 4] = grp_c[3:0];
            cy_c  = grp_c[4];
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic             v_q, v_d;
         logic             c_q, c_d;
         logic [WIDTH-1:0] a_q, a_d;
         logic [WIDTH-1:0] b_q, b_d;
         logic [WIDTH-1:0] ps_q, ps_d;

         always_comb begin
            v_d  = v_q;
            c_d  = c_q;
            a_d  = a_q;
            b_d  = b_q;
            ps_d = ps_q;
            if (adv) begin
               v_d = v_in[k];
               if (v_in[k]) begin
                  c_d  = cy_c;
                  a_d  = a_in[k];
                  b_d  = b_in[k];
                  ps_d = sum_c;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q  <= 1'b0;
               c_q  <= 1'b0;
               a_q  <= '0;
               b_q  <= '0;
               ps_q <= '0;
            end else begin
               v_q  <= v_d;
               c_q  <= c_d;
               a_q  <= a_d;
               b_q  <= b_d;
               ps_q <= ps_d;
            end
         end

         assign v_in[k+1]  = v_q;
         assign c_in[k+1]  = c_q;
         assign a_in[k+1]  = a_q;
         assign b_in[k+1]  = b_q;
         assign ps_in[k+1] = ps_q;
      end else begin : g_last
         logic             ov_c;
         logic [WIDTH-1:0] res_c;
         logic [WIDTH-1:0] s_d;
         logic             co_d;
         logic             ov_d;
         logic             out_valid_d;

         always_comb begin
            ov_c = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1])
                && (sum_c[WIDTH-1] != a_in[k][WIDTH-1]);
`ifdef PIPE_CLA_ADDER_SAT_EN
            res_c = ov_c ? {a_in[k][WIDTH-1], {(WIDTH-1){~a_in[k][WIDTH-1]}}}
                         : sum_c;
`else
            res_c = sum_c;
`endif
         end

         always_comb begin
            s_d         = s_q;
            co_d        = co_q;
            ov_d        = ov_q;
            out_valid_d = out_valid_q;
            if (adv) begin
               out_valid_d = v_in[k];
               if (v_in[k]) begin
                  s_d  = res_c;
                  co_d = cy_c;
                  ov_d = ov_c;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s_q         <= '0;
               co_q        <= 1'b0;
               ov_q        <= 1'b0;
               out_valid_q <= 1'b0;
            end else begin
               s_q         <= s_d;
               co_q        <= co_d;
               ov_q        <= ov_d;
               out_valid_q <= out_valid_d;
            end
         end
      end
   end

   assign s         = s_q;
   assign co        = co_q;
   assign ov        = ov_q;
   assign out_valid = out_valid_q;

endmodule
